// File: rtl/sysmem_ctrl.sv
// Bridges the picorv32 native memory bus to four 8-bit single-port BRAM lanes.
// Write completes one cycle after accept, read two; BRAM enables are combinational from the request.
module sysmem_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    output logic                 mem_ready,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_rdata,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [3:0]           ram_ce,
    output logic [3:0]           ram_we,
    output logic [31:0]          ram_di,
    input  logic [31:0]          ram_do
);

    localparam int TAG_LSB = ADDR_BITS + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    logic hit;
    logic is_wr;
    logic accept;
    logic unused_sig;

    assign hit    = (mem_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign is_wr  = |mem_wstrb;
    // resetn is folded in so no lane can be written while reset is held
    assign accept = mem_valid & hit & resetn & (state_q == IDLE);

    assign ram_addr = mem_addr[TAG_LSB-1:2];
    assign ram_di   = mem_wdata;
    assign ram_ce   = accept ? (is_wr ? mem_wstrb : 4'hF) : 4'h0;
    assign ram_we   = accept ? mem_wstrb : 4'h0;

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

    assign unused_sig = ^{mem_instr, mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        state_q <= is_wr ? RESP : RD;
                        ready_q <= is_wr;
                    end
                end
                RD: begin
                    // BRAM output is valid during this cycle, one edge after the enable
                    state_q <= RESP;
                    ready_q <= 1'b1;
                    rdata_q <= ram_do;
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
